// File: rtl/baud_detect.sv
// Automatic baud-rate detector: times a 0x55 sync character on rx and
// produces the clock-divider value that regenerates baud x 2^OVS_LOG2.
module baud_detect #(
  parameter int CLK_CNT_WIDTH = 16,
  parameter int OVS_LOG2      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     rx,
  output logic [CLK_CNT_WIDTH-1:0] div,
  output logic                     valid,
  output logic                     err,
  output logic                     busy
);

  localparam int W = CLK_CNT_WIDTH + 4 + OVS_LOG2;
  localparam int S = 4 + OVS_LOG2;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_IDLE = 3'd1;
  localparam logic [2:0] WAIT_FALL = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] CALC      = 3'd4;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W:0]   ROUND   = (W+1)'(2 ** (S - 1));

  logic [2:0]   state;
  logic         rx_s1, rx_s2, rx_prev;
  logic         fall;
  logic [W-1:0] icnt, tcnt, ref_ivl;
  logic [2:0]   ecnt;
  logic [W:0]   ivl, dif, qsum, q;
  logic         tol_ok;

  assign fall = rx_prev & ~rx_s2;
  assign busy = (state != IDLE);

  // Interval ending at the fall seen this cycle, and its distance from the reference.
  always_comb begin
    ivl    = {1'b0, icnt} + 1'b1;
    dif    = (ivl >= {1'b0, ref_ivl}) ? ivl - {1'b0, ref_ivl} : {1'b0, ref_ivl} - ivl;
    tol_ok = (dif <= {3'b000, ref_ivl[W-1:2]});
    qsum   = {1'b0, tcnt} + ROUND;
    q      = qsum >> S;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      icnt    <= '0;
      tcnt    <= '0;
      ref_ivl <= '0;
      ecnt    <= '0;
      div     <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      valid   <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (rx_s2) state <= WAIT_FALL;
        end
        WAIT_FALL: begin
          if (fall) begin
            icnt  <= '0;
            tcnt  <= '0;
            ecnt  <= 3'd1;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (icnt == CNT_MAX || tcnt == CNT_MAX) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (fall) begin
              icnt <= '0;
              ecnt <= ecnt + 3'd1;
              // ecnt still holds the previous fall number here
              if (ecnt == 3'd1) begin
                ref_ivl <= ivl[W-1:0];
              end else if (!tol_ok) begin
                err   <= 1'b1;
                state <= IDLE;
              end else if (ecnt == 3'd4) begin
                state <= CALC;
              end
            end else begin
              icnt <= icnt + 1'b1;
            end
          end
        end
        CALC: begin
          if (q == '0) begin
            err <= 1'b1;
          end else begin
            div   <= CLK_CNT_WIDTH'(q - 1'b1);
            valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_detect.sv
// Bench for baud_detect: fixed vector table, hand-written corner sequences and
// randomized frames checked against an arithmetic model of the measurement.
module tb_baud_detect;

  logic        clk = 1'b0;
  logic        rst, start, rx, start_s, rx_s;
  logic [15:0] div0, div4;
  logic [3:0]  divs;
  logic        valid0, err0, busy0;
  logic        valid4, err4, busy4;
  logic        valids, errs, busys;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int nv0 = 0, ne0 = 0, nb0 = 0, vcyc0 = 0, vbusy0 = 0;
  int nv4 = 0, ne4 = 0, nb4 = 0;
  int nvs = 0, nes = 0, ecycs = 0;
  int f5cyc = 0;
  int exp_last0 = 0, exp_last4 = 0;

  typedef struct {
    int p;
    int sj;
    int slen;
    bit k0;
    int d0;
    bit k4;
    int d4;
  } row_t;

  baud_detect u0 (
    .clk(clk), .rst(rst), .start(start), .rx(rx),
    .div(div0), .valid(valid0), .err(err0), .busy(busy0)
  );

  baud_detect #(.OVS_LOG2(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .rx(rx),
    .div(div4), .valid(valid4), .err(err4), .busy(busy4)
  );

  baud_detect #(.CLK_CNT_WIDTH(4)) us (
    .clk(clk), .rst(rst), .start(start_s), .rx(rx_s),
    .div(divs), .valid(valids), .err(errs), .busy(busys)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (valid0) begin nv0++; vcyc0 = cyc; vbusy0 = int'(busy0); end
      if (err0) ne0++;
      if (valid0 && err0) nb0++;
      if (valid4) nv4++;
      if (err4) ne4++;
      if (valid4 && err4) nb4++;
      if (valids) nvs++;
      if (errs) begin nes++; ecycs = cyc; end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required < 100000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Drives one 0x55-shaped frame: five falls separated by iv[0..3] clocks, each low for p.
  task automatic frame(input int p, input int iv[4], input bit mid_start);
    rx = 1'b0;
    hold(p);
    for (int j = 0; j < 4; j++) begin
      rx = 1'b1;
      if (mid_start && j == 1) start = 1'b1;
      hold(1);
      start = 1'b0;
      hold(iv[j] - p - 1);
      rx = 1'b0;
      if (j == 3) f5cyc = cyc;
      hold(p);
    end
    rx = 1'b1;
    hold(p + 8);
  endtask

  // Measurement outcome from the rules: reference interval, 25% tolerance, rounded T/2^s.
  task automatic model(input int iv[4], input int ovs, output bit ok, output int dv);
    longint t, q, r, d, maxc;
    int s;
    s = 4 + ovs;
    maxc = (longint'(1) << (20 + ovs)) - 1;
    r = iv[0];
    ok = 1'b1;
    t = 0;
    for (int j = 0; j < 4; j++) t += iv[j];
    for (int j = 1; j < 4; j++) begin
      d = iv[j] - r;
      if (d < 0) d = -d;
      if (d > r / 4) ok = 1'b0;
    end
    if (t - 1 >= maxc) ok = 1'b0;
    q = (t + (longint'(1) << (s - 1))) / (longint'(1) << s);
    if (q == 0) ok = 1'b0;
    dv = ok ? int'(q - 1) : 0;
  endtask

  task automatic run_case(input int p, input int iv[4], input bit mid,
                          input bit k0, input int d0, input bit k4, input int d4);
    int b0v, b0e, b0b, b4v, b4e, b4b;
    start = 1'b1;
    hold(1);
    start = 1'b0;
    check("busy_after_start", busy0, 1);
    hold(4);
    b0v = nv0; b0e = ne0; b0b = nb0;
    b4v = nv4; b4e = ne4; b4b = nb4;
    frame(p, iv, mid);
    check("valid_cnt0", nv0 - b0v, k0 ? 1 : 0);
    check("err_cnt0", ne0 - b0e, k0 ? 0 : 1);
    check("div0", div0, d0);
    check("both0", nb0 - b0b, 0);
    check("valid_cnt4", nv4 - b4v, k4 ? 1 : 0);
    check("err_cnt4", ne4 - b4e, k4 ? 0 : 1);
    check("div4", div4, d4);
    check("both4", nb4 - b4b, 0);
    check("busy_end", busy0, 0);
    if (k0 && nv0 - b0v == 1) begin
      check("valid_latency", vcyc0 - f5cyc, 4);
      check("busy_at_valid", vbusy0, 0);
    end
  endtask

  initial begin
    row_t tbl[9];
    int   iv[4];
    int   c0, be, bv;
    bit   k0, k4;
    int   d0, d4, p, r;

    tbl[0] = '{434, -1, 0,    1'b1, 216, 1'b1, 13};
    tbl[1] = '{100, -1, 0,    1'b1, 49,  1'b1, 2};
    tbl[2] = '{434, 3,  1216, 1'b0, 49,  1'b0, 2};
    tbl[3] = '{16,  -1, 0,    1'b1, 7,   1'b1, 0};
    tbl[4] = '{8,   -1, 0,    1'b1, 3,   1'b0, 0};
    tbl[5] = '{434, 3,  1085, 1'b1, 230, 1'b1, 13};
    tbl[6] = '{434, 3,  1086, 1'b0, 230, 1'b0, 13};
    tbl[7] = '{434, 3,  651,  1'b1, 202, 1'b1, 12};
    tbl[8] = '{700, -1, 0,    1'b1, 349, 1'b1, 21};

    rst = 1'b1; start = 1'b0; rx = 1'b1; start_s = 1'b0; rx_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_div", div0, 0);
    check("rst_valid", valid0, 0);
    check("rst_err", err0, 0);
    check("rst_busy", busy0, 0);
    check("rst_div4", div4, 0);
    rst = 1'b0;
    hold(3);

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 4; j++) iv[j] = 2 * tbl[i].p;
      if (tbl[i].sj >= 0) iv[tbl[i].sj] = tbl[i].slen;
      run_case(tbl[i].p, iv, 1'b0, tbl[i].k0, tbl[i].d0, tbl[i].k4, tbl[i].d4);
    end
    exp_last0 = 349;
    exp_last4 = 21;

    // Arm while the line is low, then a second start in the middle of the measurement.
    rx = 1'b0;
    hold(10);
    be = ne0; bv = nv0;
    start = 1'b1;
    hold(1);
    start = 1'b0;
    hold(50);
    check("arm_low_busy", busy0, 1);
    check("arm_low_pulses", (ne0 - be) + (nv0 - bv), 0);
    rx = 1'b1;
    hold(10);
    be = ne0; bv = nv0;
    for (int j = 0; j < 4; j++) iv[j] = 868;
    frame(434, iv, 1'b1);
    check("arm_low_valid", nv0 - bv, 1);
    check("arm_low_err", ne0 - be, 0);
    check("arm_low_div", div0, 216);
    check("mid_start_latency", vcyc0 - f5cyc, 4);

    // Reset after the third fall discards the measurement silently.
    start = 1'b1;
    hold(1);
    start = 1'b0;
    hold(4);
    be = ne0; bv = nv0;
    rx = 1'b0; hold(434);
    rx = 1'b1; hold(434);
    rx = 1'b0; hold(434);
    rx = 1'b1; hold(434);
    rx = 1'b0; hold(4);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    check("rstmid_div", div0, 0);
    check("rstmid_busy", busy0, 0);
    check("rstmid_div4", div4, 0);
    hold(5);
    rx = 1'b1;
    hold(440);
    check("rstmid_pulses", (ne0 - be) + (nv0 - bv), 0);
    run_case(434, iv, 1'b0, 1'b1, 216, 1'b1, 13);
    exp_last0 = 216;
    exp_last4 = 13;

    for (int n = 0; n < 12; n++) begin
      p = int'($urandom_range(120, 8));
      r = (n % 2 == 0) ? p / 4 : (3 * p) / 4;
      for (int j = 0; j < 4; j++) iv[j] = 2 * p - r + int'($urandom_range(2 * r, 0));
      model(iv, 0, k0, d0);
      model(iv, 4, k4, d4);
      if (k0) exp_last0 = d0;
      if (k4) exp_last4 = d4;
      run_case(p, iv, 1'b0, k0, exp_last0, k4, exp_last4);
    end

    // Timeout on the narrow instance: one fall, then icnt runs to 2^8-1.
    start_s = 1'b1;
    hold(1);
    start_s = 1'b0;
    hold(256);
    check("tmo_busy_wait", busys, 1);
    be = nes; bv = nvs;
    rx_s = 1'b0;
    c0 = cyc;
    hold(300);
    check("tmo_err", nes - be, 1);
    check("tmo_valid", nvs - bv, 0);
    check("tmo_latency", ecycs - c0, 259);
    check("tmo_div", divs, 0);
    check("tmo_busy", busys, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/baud_detect.md
# baud_detect

Automatic baud-rate detector for the FPGA-side UART. Armed by `start`, it times a received 0x55 sync character on `rx` and produces the divider value that, loaded into the design's clock divider, regenerates the measured bit rate (times a power-of-two oversample factor). It sits between the UART RX pin and the divider's `div` input, and is the measuring counterpart of that divider.

## Interface
- `CLK_CNT_WIDTH`, 16: width of the `div` output; matches the clock divider's counter width.
- `OVS_LOG2`, 0: log2 of the oversample factor, legal range 0-4. The regenerated clock frequency is baud × 2^OVS_LOG2.
- `clk`  in  1  sole clock; every register is clocked on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle arm request; honoured only in IDLE.
- `rx`  in  1  asynchronous UART line, idle high.
- `div`  out  CLK_CNT_WIDTH  measured divider value; holds its last good value.
- `valid`  out  1  one-cycle pulse when `div` is updated.
- `err`  out  1  one-cycle pulse when a measurement is aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. A third flop holds the previous synced value. A fall is synced 1→0 across that pair.
- **Line pattern:** 0x55 sent LSB first gives the sequence start 0, then 1 0 1 0 1 0 1 0, then stop 1. Its five falls are 2 bit-times apart, so the time from fall 1 to fall 5 is T = 8 bit-times.
- **Internal width:** W = CLK_CNT_WIDTH + 4 + OVS_LOG2, used for the interval counter `icnt`, the total counter `tcnt` and the stored reference interval `ref`.
- **FSM states:** IDLE, WAIT_IDLE, WAIT_FALL, MEASURE, CALC.
- **IDLE:** `start` → WAIT_IDLE.
- **WAIT_IDLE:** synced rx = 1 → WAIT_FALL. This prevents arming in the middle of a character.
- **WAIT_FALL:** a fall → MEASURE. On entry, clear `icnt` and `tcnt` and set edge count = 1.
- **MEASURE, counting:** `icnt` and `tcnt` increment every cycle.
- **MEASURE, each fall:** the interval I = `icnt` + 1. Then clear `icnt` and increment the edge count.
  - Fall 2: store `ref` = I.
  - Falls 3-5: require |I − ref| ≤ ref >> 2, otherwise abort.
  - Fall 5 → CALC.
- **CALC (exactly 1 cycle):**
  - s = 4 + OVS_LOG2.
  - q = (T + 2^(s−1)) >> s, computed with W+1 bits.
  - If q = 0, abort.
  - Otherwise `div` ← q − 1, pulse `valid`, → IDLE.
- **Abort:** pulse `err`, → IDLE, `div` unchanged. Abort conditions:
  - `icnt` or `tcnt` reaches 2^W − 1 (timeout or saturation);
  - tolerance violation;
  - q = 0.
- **`start` outside IDLE:** ignored. A measurement is never restarted.
- **`rst` in any cycle:** FSM → IDLE, all counters → 0, `div` → 0, `valid`/`err`/`busy` → 0, sync flops → 1. A measurement in progress is discarded with no `err` pulse.

## Timing
- **Reset values:** `div` = 0, `valid` = 0, `err` = 0, `busy` = 0.
- **`start` response:** `start` sampled high in IDLE gives `busy` = 1 on the next cycle.
- **Pin-to-fall latency:** the rx pin reaches fall detection after 3 cycles. The latency is constant, so intervals are unaffected.
- **Fall 1 detected in cycle k:** MEASURE from cycle k+1; T counts cycles k+1 through fall 5 inclusive.
- **Fall 5 detected in cycle m:**
  - CALC occupies cycle m+1.
  - `div`/`valid` (or `err`) are registered at the end of m+1 and visible during cycle m+2.
  - `busy` = 0 in cycle m+2.
- **`valid` and `err`:** never high together; each is high for exactly one cycle.
- **Two falls within the 3-flop window:** each fall is counted separately. With 8-bit-time frames at legal rates this cannot occur.
- **`rx` glitch on the start bit:** produces a short interval, which the tolerance check rejects.

## Test plan
- **Nominal:** OVS_LOG2 = 0, bit period 434 clk, 0x55 sent after `start` → `valid` pulse, `div` = 216, `err` never high, `busy` low the cycle `valid` is seen.
- **Oversample:** OVS_LOG2 = 4, bit period 434 clk → `div` = 13. Bit period 16 clk → q = 1, `div` = 0.
- **Tolerance:** 0x55 with the fourth fall-to-fall interval stretched from 868 to 1216 clk (40% long) → `err` pulse, no `valid`, `div` keeps its previous value.
- **Timeout:** `start` with `rx` held high for 2^W clk, then low with no further falls → `err` pulse when `icnt` saturates, then IDLE.
- **Arm while line low / start while busy:** `rx` low at `start` → no progress until `rx` returns high. A second `start` mid-MEASURE → ignored, result identical to the nominal case.
- **Reset mid-measure:** assert `rst` after fall 3 → next cycle `div` = 0, `busy` = 0, no `err`. A fresh `start` plus 0x55 then yields `div` = 216.
